// File: rtl/mem_stage_pkg.sv
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared types and constants for the MEM pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_stage_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_GNT = 2'd1,
        ST_WAIT_RSP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Unlisted load encodings (011/110/111) fall into the word case.
    function automatic size_e access_size(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LBU: access_size = SZ_BYTE;
            F3_LH, F3_LHU: access_size = SZ_HALF;
            default:       access_size = SZ_WORD;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_if.sv
// ============================================================================
// Module      : mem_stage_if
// Description : Data-memory request/response bus between MEM stage and memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_stage_if;
    import mem_stage_pkg::*;

    logic            dmem_req_o;
    logic            dmem_we_o;
    logic [3:0]      dmem_be_o;
    logic [XLEN-1:0] dmem_addr_o;
    logic [XLEN-1:0] dmem_wdata_o;
    logic            dmem_gnt_i;
    logic            dmem_rvalid_i;
    logic [XLEN-1:0] dmem_rdata_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o,
        input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o,
        output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );

endinterface

`default_nettype wire

// File: rtl/mem_stage_load_align.sv
// ============================================================================
// Module      : load_align
// Description : Byte-lane extract and sign/zero extension of load data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align
    import mem_stage_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      offset_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o
);

    logic [XLEN-1:0] shifted;

    assign shifted = rdata_i >> {offset_i, 3'b000};

    always_comb begin
        case (funct3_i)
            F3_LB:   data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_LBU:  data_o = {24'd0, shifted[7:0]};
            F3_LH:   data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_LHU:  data_o = {16'd0, shifted[15:0]};
            F3_LW:   data_o = rdata_i;
            default: data_o = rdata_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module      : mem_stage
// Description : Pipeline MEM stage: data-memory handshake FSM, store lane
//               steering, load alignment and the MEM/WB register.
//               Optional feature macro: MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage
    import mem_stage_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            reg_write_M,
    input  logic            mem_write_M,
    input  logic [1:0]      wb_sel_M,
    input  logic [4:0]      rd_M,
    input  logic [XLEN-1:0] pc_M,
    input  logic [XLEN-1:0] alu_result_M,
    input  logic [XLEN-1:0] rs2_data_M,
    input  logic [2:0]      funct3_M,

    mem_stage_if.master     dmem,

    output logic            stall_o,

    output logic            reg_write_W,
    output logic [1:0]      wb_sel_W,
    output logic [4:0]      rd_W,
    output logic [XLEN-1:0] pc_W,
    output logic [XLEN-1:0] alu_result_W,
    output logic [XLEN-1:0] ld_data_W,
    output logic            misalign_W
);

    state_e          state_q, state_d;
    size_e           size;
    logic [1:0]      offset;
    logic            is_store, is_load, mem_op, misalign, mem_op_eff;
    logic            req, store_done, load_done, stall;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] ld_ext;

    assign is_store = mem_write_M;
    assign is_load  = (wb_sel_M == WB_MEM) && !mem_write_M;
    assign mem_op   = is_store || is_load;
    assign size     = access_size(funct3_M);

`ifdef MISALIGN_TRAP_EN
    assign misalign = mem_op &&
                      (((size == SZ_HALF) && alu_result_M[0]) ||
                       ((size == SZ_WORD) && (alu_result_M[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    // A trapped access never touches memory and retires in one cycle.
    assign mem_op_eff = mem_op && !misalign;

    // Low address bits are rounded down to the natural alignment of the access.
    always_comb begin
        offset = 2'b00;
        be     = 4'b1111;
        wdata  = rs2_data_M;
        case (size)
            SZ_BYTE: begin
                offset = alu_result_M[1:0];
                be     = 4'b0001 << offset;
                wdata  = {4{rs2_data_M[7:0]}};
            end
            SZ_HALF: begin
                offset = {alu_result_M[1], 1'b0};
                be     = 4'b0011 << offset;
                wdata  = {2{rs2_data_M[15:0]}};
            end
            default: begin
                offset = 2'b00;
                be     = 4'b1111;
                wdata  = rs2_data_M;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        req        = rst_ni && mem_op_eff && (state_q != ST_WAIT_RSP);
        store_done = req && is_store && dmem.dmem_gnt_i;
        load_done  = (state_q == ST_WAIT_RSP) && dmem.dmem_rvalid_i;
        stall      = rst_ni && mem_op_eff && !store_done && !load_done;
        case (state_q)
            ST_IDLE, ST_WAIT_GNT: begin
                if (!mem_op_eff)            state_d = ST_IDLE;
                else if (!dmem.dmem_gnt_i)  state_d = ST_WAIT_GNT;
                else if (is_store)          state_d = ST_IDLE;
                else                        state_d = ST_WAIT_RSP;
            end
            ST_WAIT_RSP: begin
                if (dmem.dmem_rvalid_i)     state_d = ST_IDLE;
            end
            default:                        state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    load_align u_load_align (
        .rdata_i  (dmem.dmem_rdata_i),
        .offset_i (offset),
        .funct3_i (funct3_M),
        .data_o   (ld_ext)
    );

    assign dmem.dmem_req_o   = req;
    assign dmem.dmem_we_o    = is_store;
    assign dmem.dmem_be_o    = be;
    assign dmem.dmem_addr_o  = {alu_result_M[XLEN-1:2], 2'b00};
    assign dmem.dmem_wdata_o = wdata;
    assign stall_o           = stall;

    // While stalled the W stage sees a bubble; payload holds its last value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reg_write_W  <= 1'b0;
            wb_sel_W     <= 2'b00;
            rd_W         <= 5'd0;
            pc_W         <= '0;
            alu_result_W <= '0;
            ld_data_W    <= '0;
            misalign_W   <= 1'b0;
        end else if (stall) begin
            reg_write_W  <= 1'b0;
        end else begin
            reg_write_W  <= reg_write_M && !misalign;
            wb_sel_W     <= wb_sel_M;
            rd_W         <= rd_M;
            pc_W         <= pc_M;
            alu_result_W <= alu_result_M;
            ld_data_W    <= load_done ? ld_ext : '0;
            misalign_W   <= misalign;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage with a byte-count based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk_i;
    logic        rst_ni;
    logic        reg_write_M, mem_write_M;
    logic [1:0]  wb_sel_M;
    logic [4:0]  rd_M;
    logic [31:0] pc_M, alu_result_M, rs2_data_M;
    logic [2:0]  funct3_M;
    logic        stall_o;
    logic        reg_write_W;
    logic [1:0]  wb_sel_W;
    logic [4:0]  rd_W;
    logic [31:0] pc_W, alu_result_W, ld_data_W;
    logic        misalign_W;

    int checks   = 0;
    int failures = 0;
    bit trap_en;

    mem_stage_if dmem_bus ();

    mem_stage dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .reg_write_M  (reg_write_M),
        .mem_write_M  (mem_write_M),
        .wb_sel_M     (wb_sel_M),
        .rd_M         (rd_M),
        .pc_M         (pc_M),
        .alu_result_M (alu_result_M),
        .rs2_data_M   (rs2_data_M),
        .funct3_M     (funct3_M),
        .dmem         (dmem_bus),
        .stall_o      (stall_o),
        .reg_write_W  (reg_write_W),
        .wb_sel_W     (wb_sel_W),
        .rd_W         (rd_W),
        .pc_W         (pc_W),
        .alu_result_W (alu_result_W),
        .ld_data_W    (ld_data_W),
        .misalign_W   (misalign_W)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_alu(input logic rw, input logic [4:0] rd, input logic [31:0] res,
                           input logic [31:0] pc, input logic [1:0] wb);
        reg_write_M = rw; mem_write_M = 1'b0; wb_sel_M = wb; rd_M = rd;
        pc_M = pc; alu_result_M = res; rs2_data_M = $urandom; funct3_M = 3'($urandom_range(7));
        dmem_bus.dmem_gnt_i = 1'b0; dmem_bus.dmem_rvalid_i = 1'b0;
        @(negedge clk_i);
        chk("alu_req", dmem_bus.dmem_req_o, 1'b0);
        chk("alu_stall", stall_o, 1'b0);
        next_cycle();
        chk("alu_rw_W", reg_write_W, rw);
        chk("alu_res_W", alu_result_W, res);
        chk("alu_rd_W", rd_W, rd);
        chk("alu_pc_W", pc_W, pc);
        chk("alu_wbsel_W", wb_sel_W, wb);
        chk("alu_ld_W", ld_data_W, 32'd0);
    endtask

    // Model: access width in bytes, offset rounded down to a multiple of it.
    task automatic run_mem(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rs2, input logic [31:0] rdat,
                           input int gd, input int rdly, input logic [4:0] rd,
                           input logic [31:0] pc);
        int unsigned n, off, exp_stalls, stalls, c;
        logic [31:0] mask, val, be_e, wd_e, ld_e;
        bit mis, done;
        n    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        mis  = ((a % n) != 0);
        off  = ((a % 4) / n) * n;
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 1);
        val  = (rdat >> (8 * off)) & mask;
        if (n < 4 && f3[2] == 1'b0 && val[8*n-1]) val = val | ~mask;
        ld_e = (n == 4) ? rdat : val;
        be_e = ((32'd1 << n) - 1) << off;
        wd_e = (n == 1) ? rs2[7:0] * 32'h0101_0101 :
               (n == 2) ? rs2[15:0] * 32'h0001_0001 : rs2;

        reg_write_M = !st; mem_write_M = st; wb_sel_M = st ? WB_ALU : WB_MEM;
        rd_M = rd; pc_M = pc; alu_result_M = a; rs2_data_M = rs2; funct3_M = f3;

        if (trap_en && mis) begin
            dmem_bus.dmem_gnt_i = 1'b0; dmem_bus.dmem_rvalid_i = 1'b0;
            @(negedge clk_i);
            chk("trap_req", dmem_bus.dmem_req_o, 1'b0);
            chk("trap_stall", stall_o, 1'b0);
            next_cycle();
            chk("trap_mis_W", misalign_W, 1'b1);
            chk("trap_rw_W", reg_write_W, 1'b0);
            chk("trap_ld_W", ld_data_W, 32'd0);
            return;
        end

        exp_stalls = st ? gd : gd + 1 + rdly;
        stalls = 0; c = 0; done = 0;
        while (!done && c < 40) begin
            dmem_bus.dmem_gnt_i    = (c == gd);
            dmem_bus.dmem_rvalid_i = st ? 1'b0 :
                                     ((c == gd + 1 + rdly) || (c <= gd && $urandom_range(1) == 1));
            dmem_bus.dmem_rdata_i  = (c == gd + 1 + rdly) ? rdat : $urandom;
            @(negedge clk_i);
            if (c <= gd) begin
                chk("req_hi", dmem_bus.dmem_req_o, 1'b1);
                chk("addr", dmem_bus.dmem_addr_o, a & 32'hFFFF_FFFC);
                chk("we", dmem_bus.dmem_we_o, st);
                if (st) begin
                    chk("be", dmem_bus.dmem_be_o, be_e);
                    chk("wdata", dmem_bus.dmem_wdata_o, wd_e);
                end
            end else begin
                chk("req_lo", dmem_bus.dmem_req_o, 1'b0);
            end
            if (c >= 1) chk("bubble_rw_W", reg_write_W, 1'b0);
            if (stall_o) stalls++;
            else done = 1;
            next_cycle();
            c++;
        end
        dmem_bus.dmem_gnt_i = 1'b0; dmem_bus.dmem_rvalid_i = 1'b0;
        chk("stall_cycles", stalls, exp_stalls);
        chk("mem_rw_W", reg_write_W, !st);
        chk("mem_res_W", alu_result_W, a);
        chk("mem_rd_W", rd_W, rd);
        chk("mem_pc_W", pc_W, pc);
        chk("mem_ld_W", ld_data_W, st ? 32'd0 : ld_e);
        chk("mem_mis_W", misalign_W, 1'b0);
    endtask

    initial begin
`ifdef MISALIGN_TRAP_EN
        trap_en = 1'b1;
`else
        trap_en = 1'b0;
`endif
        rst_ni = 1'b0;
        reg_write_M = 1'b1; mem_write_M = 1'b0; wb_sel_M = WB_MEM; rd_M = 5'd3;
        pc_M = 32'h10; alu_result_M = 32'h100; rs2_data_M = 32'd0; funct3_M = F3_LW;
        dmem_bus.dmem_gnt_i = 1'b0; dmem_bus.dmem_rvalid_i = 1'b0; dmem_bus.dmem_rdata_i = 32'd0;
        #2;
        chk("rst_req", dmem_bus.dmem_req_o, 1'b0);
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_rw_W", reg_write_W, 1'b0);
        chk("rst_res_W", alu_result_W, 32'd0);
        chk("rst_ld_W", ld_data_W, 32'd0);
        chk("rst_mis_W", misalign_W, 1'b0);
        next_cycle();
        next_cycle();
        mem_write_M = 1'b0; wb_sel_M = WB_ALU;
        rst_ni = 1'b1;

        // Directed scenarios
        run_mem(1'b1, F3_SW, 32'h100, 32'hDEAD_BEEF, 32'd0, 0, 0, 5'd0, 32'h1000);
        run_mem(1'b0, F3_LB, 32'h103, 32'd0, 32'h80FF_FFFF, 2, 0, 5'd4, 32'h1004);
        chk("lb_value", ld_data_W, 32'hFFFF_FF80);
        run_mem(1'b0, F3_LHU, 32'h202, 32'd0, 32'h8001_0000, 1, 1, 5'd6, 32'h1008);
        run_mem(1'b1, F3_SH, 32'h202, 32'h1234_BEEF, 32'd0, 1, 0, 5'd0, 32'h100C);
        run_alu(1'b1, 5'd5, 32'h55, 32'h1010, WB_ALU);
        run_mem(1'b0, F3_LW, 32'h101, 32'd0, 32'hCAFE_F00D, 0, 2, 5'd8, 32'h1014);
        run_mem(1'b1, F3_SB, 32'h3FF, 32'h0000_00A5, 32'd0, 3, 0, 5'd0, 32'h1018);
        run_mem(1'b0, 3'b110, 32'h44, 32'd0, 32'h1357_9BDF, 0, 0, 5'd9, 32'h101C);

        // Reset while a load waits for its response
        run_alu(1'b1, 5'd5, 32'h55, 32'h1020, WB_PC4);
        reg_write_M = 1'b1; mem_write_M = 1'b0; wb_sel_M = WB_MEM; rd_M = 5'd9;
        pc_M = 32'h1024; alu_result_M = 32'h300; funct3_M = F3_LW;
        dmem_bus.dmem_gnt_i = 1'b1; dmem_bus.dmem_rvalid_i = 1'b0;
        @(negedge clk_i);
        chk("rr_req", dmem_bus.dmem_req_o, 1'b1);
        next_cycle();
        dmem_bus.dmem_gnt_i = 1'b0;
        @(negedge clk_i);
        chk("rr_wait_stall", stall_o, 1'b1);
        chk("rr_wait_req", dmem_bus.dmem_req_o, 1'b0);
        #1 rst_ni = 1'b0;
        #1;
        chk("rr_stall", stall_o, 1'b0);
        chk("rr_req_rst", dmem_bus.dmem_req_o, 1'b0);
        chk("rr_res_W", alu_result_W, 32'd0);
        chk("rr_pc_W", pc_W, 32'd0);
        chk("rr_wbsel_W", wb_sel_W, 2'b00);
        reg_write_M = 1'b1; wb_sel_M = WB_ALU; rd_M = 5'd7; pc_M = 32'h40; alu_result_M = 32'h77;
        next_cycle();
        rst_ni = 1'b1;
        dmem_bus.dmem_rvalid_i = 1'b1; dmem_bus.dmem_rdata_i = 32'h1234_5678;
        @(negedge clk_i);
        chk("late_rsp_stall", stall_o, 1'b0);
        chk("late_rsp_req", dmem_bus.dmem_req_o, 1'b0);
        next_cycle();
        dmem_bus.dmem_rvalid_i = 1'b0;
        chk("late_rsp_rw_W", reg_write_W, 1'b1);
        chk("late_rsp_res_W", alu_result_W, 32'h77);
        chk("late_rsp_ld_W", ld_data_W, 32'd0);
        run_mem(1'b0, F3_LH, 32'h206, 32'd0, 32'hF00D_1234, 1, 0, 5'd10, 32'h1028);

        // Randomized mix of ALU ops, loads and stores
        for (int i = 0; i < 40; i++) begin
            int unsigned kind;
            kind = $urandom_range(2);
            if (kind == 0)
                run_alu(1'($urandom_range(1)), 5'($urandom), $urandom, $urandom,
                        ($urandom_range(1) == 1) ? WB_PC4 : WB_ALU);
            else if (kind == 1)
                run_mem(1'b0, 3'($urandom_range(7)), $urandom, $urandom, $urandom,
                        $urandom_range(3), $urandom_range(2), 5'($urandom), $urandom);
            else
                run_mem(1'b1, 3'($urandom_range(2)), $urandom, $urandom, 32'd0,
                        $urandom_range(3), 0, 5'd0, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
